// File: rtl/queue_fifo_display_pkg.sv
// Shared constants for the push-button FIFO display: seven-segment glyphs
// ({g,f,e,d,c,b,a}, 1 = lit) and the hex decoder used for both digits.
package queue_fifo_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b1111100;
    localparam logic [6:0] SEG_C = 7'b0111001;
    localparam logic [6:0] SEG_D = 7'b1011110;
    localparam logic [6:0] SEG_E = 7'b1111001;
    localparam logic [6:0] SEG_F = 7'b1110001;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/queue_fifo_display_btn_pulse.sv
// Push-button conditioner: 2-flop synchroniser, down-counting debouncer and
// single-cycle pulse on each accepted press.
module btn_pulse #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic pulse
);
    localparam int CNTW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(DEB_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d;
    logic            armed_q, armed_d;
    logic            pulse_q, pulse_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    // The synchroniser resets to "pressed" and pulses need a low sample first,
    // so a button held through reset release never produces a press.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = CNT_LOAD;
        pulse_d  = 1'b0;
        armed_d  = armed_q | ~sync2_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == '0) begin
                stable_d = sync2_q;
                pulse_d  = sync2_q & armed_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b0;
            cnt_q    <= CNT_LOAD;
            armed_q  <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            pulse_q  <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/queue_fifo_display.sv
// Button-driven FIFO with sticky error flags and seven-segment readout of
// the head entry and the occupancy.
module queue_fifo_display
    import queue_fifo_display_pkg::*;
#(
    parameter int DW         = 4,
    parameter int DEPTH      = 8,
    parameter int DEB_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DW-1:0]            data_in,
    input  logic                     push_btn,
    input  logic                     pop_btn,
    input  logic                     enable,
    output logic [DW-1:0]            data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    output logic [6:0]               Sout,
    output logic [6:0]               Cout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic          push_pulse, pop_pulse;
    logic          push_ev, pop_ev, do_push, do_pop;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d, full_q, full_d;
    logic          overflow_q, overflow_d, underflow_q, underflow_d;
    logic [DW-1:0] mem_q [DEPTH];

    btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_push (
        .clk(clk), .reset(reset), .btn_raw(push_btn), .pulse(push_pulse)
    );
    btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_pop (
        .clk(clk), .reset(reset), .btn_raw(pop_btn), .pulse(pop_pulse)
    );

    // A push while full still lands when a pop frees the head slot this cycle.
    always_comb begin
        push_ev     = push_pulse & enable;
        pop_ev      = pop_pulse & enable;
        do_pop      = pop_ev & ~empty_q;
        do_push     = push_ev & (~full_q | pop_ev);
        wr_ptr_d    = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
        empty_d     = (count_d == '0);
        full_d      = (count_d == DEPTH_C);
        overflow_d  = overflow_q | (push_ev & ~pop_ev & full_q);
        underflow_d = underflow_q | (pop_ev & empty_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign Sout      = empty_q ? SEG_BLANK : hex_to_seg(data_out[3:0]);
    assign Cout      = hex_to_seg(4'(count_q));

endmodule

// File: tb/tb_queue_fifo_display.sv
// Directed and random button sequences checked against a queue-based model.
module tb_queue_fifo_display;
    localparam int DW    = 4;
    localparam int DEPTH = 8;
    localparam int DEB   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          push_btn = 1'b0, pop_btn = 1'b0, enable = 1'b1;
    logic [DW-1:0] data_out;
    logic          full, empty, overflow, underflow;
    logic [3:0]    count;
    logic [6:0]    Sout, Cout;

    queue_fifo_display #(.DW(DW), .DEPTH(DEPTH), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .push_btn(push_btn),
        .pop_btn(pop_btn), .enable(enable), .data_out(data_out), .full(full),
        .empty(empty), .count(count), .overflow(overflow), .underflow(underflow),
        .Sout(Sout), .Cout(Cout)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [3:0] mq[$];
    bit         m_ovf = 0, m_unf = 0;
    logic [6:0] seg_tab [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic model(input bit p, input bit q, input logic [3:0] d);
        if (p && q) begin
            if (mq.size() == 0) begin
                mq.push_back(d);
                m_unf = 1;
            end else begin
                mq.delete(0);
                mq.push_back(d);
            end
        end else if (p) begin
            if (mq.size() == DEPTH) m_ovf = 1;
            else mq.push_back(d);
        end else if (q) begin
            if (mq.size() == 0) m_unf = 1;
            else mq.delete(0);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        logic [3:0] head;
        n = mq.size();
        head = (n > 0) ? mq[0] : 4'h0;
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        chk({tag, ".data_out"}, 32'(data_out), 32'(head));
        chk({tag, ".Sout"}, 32'(Sout), (n > 0) ? 32'(seg_tab[head]) : 32'h0);
        chk({tag, ".Cout"}, 32'(Cout), 32'(seg_tab[n]));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic op(input bit p, input bit q, input logic [3:0] d);
        data_in  = d;
        push_btn = p;
        pop_btn  = q;
        wait_cyc(DEB + 6);
        push_btn = 0;
        pop_btn  = 0;
        wait_cyc(DEB + 6);
        if (enable) model(p, q, d);
    endtask

    task automatic do_reset();
        reset = 0;
        model_reset();
        wait_cyc(3);
        reset = 1;
        wait_cyc(5);
    endtask

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        model_reset();
        wait_cyc(3);
        check_all("reset");
        reset = 1;
        wait_cyc(5);

        op(1, 0, 4'h3); op(1, 0, 4'h7); op(1, 0, 4'hA);
        check_all("push3");
        op(0, 1, 4'h0);
        check_all("pop1");
        op(0, 1, 4'h0); op(0, 1, 4'h0);
        op(0, 1, 4'h0);
        check_all("pop_empty");
        op(1, 0, 4'h2); op(1, 0, 4'h5);
        check_all("unf_sticky");

        do_reset();
        for (int i = 0; i < 8; i++) op(1, 0, 4'(i + 1));
        check_all("fill8");
        op(1, 0, 4'hE);
        check_all("overflow9");

        do_reset();
        data_in = 4'h6;
        push_btn = 1; wait_cyc(1);
        push_btn = 0; wait_cyc(1);
        push_btn = 1; wait_cyc(20);
        push_btn = 0; wait_cyc(12);
        model(1, 0, 4'h6);
        check_all("bounce");
        enable = 0;
        op(1, 0, 4'h9);
        op(0, 1, 4'h0);
        enable = 1;
        check_all("disabled");

        do_reset();
        for (int i = 0; i < 4; i++) op(1, 0, 4'(i + 8));
        op(1, 1, 4'hD);
        check_all("both_mid");
        for (int i = 0; i < 4; i++) op(1, 0, 4'(i + 1));
        op(1, 1, 4'hB);
        check_all("both_full");

        do_reset();
        op(1, 1, 4'h4);
        check_all("both_empty");

        for (int i = 0; i < 40; i++) begin
            bit p, q;
            p = 1'($urandom_range(0, 1));
            q = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 3) != 0);
            op(p, q, 4'($urandom));
            check_all("random");
        end
        enable = 1;

        data_in = 4'h5;
        push_btn = 1;
        wait_cyc(3);
        #2 reset = 0;
        model_reset();
        #1 check_all("reset_async");
        wait_cyc(3);
        reset = 1;
        wait_cyc(20);
        check_all("held_release");
        push_btn = 0;
        wait_cyc(12);
        check_all("after_unpress");
        op(1, 0, 4'hC);
        check_all("new_press");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
